// File: rtl/intersection_ctrl.sv
// intersection_ctrl: main/side road phase sequencer with
// yellow and all-red clearance between every handover.
module intersection_ctrl #(
  parameter int CW       = 8,
  parameter int T_MG_MIN = 20,
  parameter int T_SG     = 10,
  parameter int T_Y      = 4,
  parameter int T_AR     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       side_req,
  input  logic       ped_req,
  output logic       main_r,
  output logic       main_y,
  output logic       main_g,
  output logic       side_r,
  output logic       side_y,
  output logic       side_g,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    MG  = 3'd0,
    MY  = 3'd1,
    AR1 = 3'd2,
    SG  = 3'd3,
    SY  = 3'd4,
    AR2 = 3'd5
  } state_e;

  localparam logic [CW-1:0] MG_LAST = CW'(T_MG_MIN - 1);
  localparam logic [CW-1:0] SG_LAST = CW'(T_SG - 1);
  localparam logic [CW-1:0] Y_LAST  = CW'(T_Y - 1);
  localparam logic [CW-1:0] AR_LAST = CW'(T_AR - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] timer_q, timer_d;
  logic          ped_pend_q, ped_pend_d;
  logic          walk_en_q, walk_en_d;
  logic          mg_exit;
  logic          sy_entry;

  // Next state, phase timer and pedestrian bookkeeping
  always_comb begin
    state_d = state_q;
    mg_exit = 1'b0;
    case (state_q)
      MG: begin
        if (timer_q == MG_LAST && (side_req || ped_pend_q)) begin
          state_d = MY;
          mg_exit = 1'b1;
        end
      end
      MY:  if (timer_q == Y_LAST)  state_d = AR1;
      AR1: if (timer_q == AR_LAST) state_d = SG;
      SG:  if (timer_q == SG_LAST) state_d = SY;
      SY:  if (timer_q == Y_LAST)  state_d = AR2;
      AR2: if (timer_q == AR_LAST) state_d = MG;
      default: state_d = AR2;
    endcase

    if (state_d != state_q) begin
      timer_d = '0;
    end else if (state_q != MG || timer_q != MG_LAST) begin
      timer_d = timer_q + CW'(1);
    end else begin
      timer_d = timer_q;
    end

    // a fresh button press beats the clear at the grant edge
    ped_pend_d = ped_req | (ped_pend_q & ~mg_exit);

    sy_entry = (state_d == SY) && (state_q != SY);
    if (mg_exit) begin
      walk_en_d = ped_pend_q;
    end else if (sy_entry) begin
      walk_en_d = 1'b0;
    end else begin
      walk_en_d = walk_en_q;
    end
  end

  // State registers with lamps decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= AR2;
      timer_q    <= '0;
      ped_pend_q <= 1'b0;
      walk_en_q  <= 1'b0;
      main_r     <= 1'b1;
      main_y     <= 1'b0;
      main_g     <= 1'b0;
      side_r     <= 1'b1;
      side_y     <= 1'b0;
      side_g     <= 1'b0;
      walk       <= 1'b0;
      phase      <= 3'd5;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      ped_pend_q <= ped_pend_d;
      walk_en_q  <= walk_en_d;
      main_g     <= (state_d == MG);
      main_y     <= (state_d == MY);
      main_r     <= (state_d != MG) && (state_d != MY);
      side_g     <= (state_d == SG);
      side_y     <= (state_d == SY);
      side_r     <= (state_d != SG) && (state_d != SY);
      walk       <= (state_d == SG) && walk_en_d;
      phase      <= state_d;
    end
  end

endmodule
